// File: rtl/fir_pkg.sv
// Shared types and constants for the sequential-MAC FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    ROUND = 2'd2,
    HOLD  = 2'd3
  } fir_state_t;

  // Accumulator width that cannot overflow when summing TAPS full-scale products.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  localparam logic [15:0] FIR_LP9_COEFS [0:8] = '{
    16'h04F6, 16'h0AE4, 16'h1089, 16'h1496, 16'h160F,
    16'h1496, 16'h1089, 16'h0AE4, 16'h04F6
  };

endpackage

// File: rtl/fir_mac_seq_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation to DATA_W.
module fir_round_sat #(
  parameter int ACC_W     = 36,
  parameter int OUT_SHIFT = 14,
  parameter int DATA_W    = 16
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] out_data
);

  localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (OUT_SHIFT-1);
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = ~MAXV;

  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    sum     = $signed({acc[ACC_W-1], acc}) + HALF;
    shifted = sum >>> OUT_SHIFT;
    if (shifted > MAXV)
      out_data = {1'b0, {(DATA_W-1){1'b1}}};
    else if (shifted < MINV)
      out_data = {1'b1, {(DATA_W-1){1'b0}}};
    else
      out_data = shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR: one multiplier/accumulator walks TAPS taps per sample,
// with loadable coefficients, rounded/saturated output and valid/ready streams.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 9,
  parameter int OUT_SHIFT = 14
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     coef_we,
  input  logic [$clog2(TAPS)-1:0]  coef_addr,
  input  logic [COEF_W-1:0]        coef_wdata,
  output logic                     coef_ready
);

  localparam int AW    = $clog2(TAPS);
  localparam int PW    = DATA_W + COEF_W;
  localparam int ACC_W = int'(acc_width(DATA_W, COEF_W, TAPS));
  localparam logic [AW-1:0] LAST   = AW'(TAPS-1);
  localparam logic [AW:0]   TAPS_V = (AW+1)'(TAPS);

  fir_state_t state, state_nx;

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];
  logic signed [ACC_W-1:0]  acc;
  logic [AW-1:0]            tap;
  logic signed [PW-1:0]     prod;
  logic signed [DATA_W-1:0] rounded;
  logic                     accept;
  logic                     coef_wr;

  assign accept  = (state == IDLE) && in_valid;
  assign coef_wr = coef_we && coef_ready && ({1'b0, coef_addr} < TAPS_V);
  assign prod    = PW'(hist[tap]) * PW'(coef[tap]);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)    state_nx = MAC;
      MAC:     if (tap == LAST) state_nx = ROUND;
      ROUND:                    state_nx = HOLD;
      HOLD:    if (out_ready)   state_nx = IDLE;
      default:                  state_nx = IDLE;
    endcase
  end

  // Ready flags are decoded from the next state so they are registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      coef_ready <= 1'b1;
    end else begin
      state      <= state_nx;
      in_ready   <= (state_nx == IDLE);
      coef_ready <= (state_nx == IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= '0;
      end
      acc       <= '0;
      tap       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        hist[0] <= in_data;
        for (int unsigned i = 1; i < TAPS; i++)
          hist[i] <= hist[i-1];
        acc <= '0;
        tap <= '0;
      end
      if (coef_wr)
        coef[coef_addr] <= coef_wdata;
      if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        tap <= tap + 1'b1;
      end
      if (state == ROUND) begin
        out_data  <= rounded;
        out_valid <= 1'b1;
      end
      if ((state == HOLD) && out_ready)
        out_valid <= 1'b0;
    end
  end

  fir_round_sat #(
    .ACC_W    (ACC_W),
    .OUT_SHIFT(OUT_SHIFT),
    .DATA_W   (DATA_W)
  ) u_round_sat (
    .acc     (acc),
    .out_data(rounded)
  );

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed and randomized bench for fir_mac_seq against an arithmetic FIR model.
module tb_fir_mac_seq;
  import fir_pkg::*;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int T  = 9;
  localparam int SH = 14;
  localparam int AW = $clog2(T);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          coef_we = 1'b0;
  logic [AW-1:0] coef_addr = '0;
  logic [CW-1:0] coef_wdata = '0;
  logic          coef_ready;

  int checks = 0;
  int errors = 0;
  int ref_coef [T];
  int ref_hist [T];

  fir_mac_seq #(
    .DATA_W   (DW),
    .COEF_W   (CW),
    .TAPS     (T),
    .OUT_SHIFT(SH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .coef_ready(coef_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // y[n] = sat(floor((sum_i x[n-i]*c[i] + 2^(SH-1)) / 2^SH))
  function automatic logic [15:0] model_out();
    longint acc = 0;
    longint r;
    for (int i = 0; i < T; i++)
      acc += longint'(ref_hist[i]) * longint'(ref_coef[i]);
    r = (acc + (longint'(1) << (SH-1))) >>> SH;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    return 16'(r);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < T; i++) begin
      ref_coef[i] = 0;
      ref_hist[i] = 0;
    end
  endtask

  task automatic write_coef(input int addr, input logic [15:0] val);
    check("coef_ready_idle", 32'(coef_ready), 32'd1);
    coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = val;
    tick();
    coef_we = 1'b0;
    if (addr < T) ref_coef[addr] = int'($signed(val));
  endtask

  task automatic send(input logic [15:0] x, input bit we, input int addr,
                      input logic [15:0] w, output logic [15:0] got);
    int lat;
    logic [15:0] exp;
    check("in_ready_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = x;
    if (we) begin coef_we = 1'b1; coef_addr = AW'(addr); coef_wdata = w; end
    tick();
    in_valid = 1'b0; coef_we = 1'b0;
    if (we && addr < T) ref_coef[addr] = int'($signed(w));
    for (int i = T-1; i > 0; i--) ref_hist[i] = ref_hist[i-1];
    ref_hist[0] = int'($signed(x));
    exp = model_out();
    check("in_ready_busy", 32'(in_ready), 32'd0);
    check("coef_ready_busy", 32'(coef_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat <= 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(T+1));
    check("out_data", 32'(out_data), 32'(exp));
    got = out_data;
    if (out_ready) begin
      tick();
      check("out_valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_after", 32'(in_ready), 32'd1);
    end
  endtask

  task automatic hold_release(input int k, input bit try_we);
    logic [15:0] held;
    held = out_data;
    for (int i = 0; i < k; i++) begin
      if (try_we && i == 1) begin
        coef_we = 1'b1; coef_addr = '0; coef_wdata = 16'h7777;
      end
      tick();
      coef_we = 1'b0;
      check("hold_data", 32'(out_data), 32'(held));
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] lp;
    model_clear();

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_coef_ready", 32'(coef_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Impulse response with the low-pass set
    for (int k = 0; k < T; k++) begin
      lp = FIR_LP9_COEFS[k];
      write_coef(k, lp);
    end
    for (int k = 0; k < T; k++) begin
      lp = FIR_LP9_COEFS[k];
      send((k == 0) ? 16'h4000 : 16'h0000, 1'b0, 0, 16'h0, got);
      check("impulse", 32'(got), 32'(lp));
    end

    // Backpressure with a dropped coefficient write, then impulse readback
    out_ready = 1'b0;
    send(16'h1234, 1'b0, 0, 16'h0, got);
    hold_release(5, 1'b1);
    for (int k = 0; k < T-1; k++) send(16'h0000, 1'b0, 0, 16'h0, got);
    for (int k = 0; k < T; k++) begin
      lp = FIR_LP9_COEFS[k];
      send((k == 0) ? 16'h4000 : 16'h0000, 1'b0, 0, 16'h0, got);
      check("impulse_readback", 32'(got), 32'(lp));
    end

    // Saturation in both directions
    for (int k = 0; k < T; k++) write_coef(k, 16'h7FFF);
    for (int k = 0; k < T; k++) send(16'h7FFF, 1'b0, 0, 16'h0, got);
    check("sat_pos", 32'(got), 32'h7FFF);
    for (int k = 0; k < T; k++) send(16'h8000, 1'b0, 0, 16'h0, got);
    check("sat_neg", 32'(got), 32'h8000);

    // Rounding at the half-LSB boundary
    write_coef(0, 16'h0001);
    for (int k = 1; k < T; k++) write_coef(k, 16'h0000);
    send(16'h2000, 1'b0, 0, 16'h0, got);
    check("round_half", 32'(got), 32'h0001);
    send(16'h1FFF, 1'b0, 0, 16'h0, got);
    check("round_below", 32'(got), 32'h0000);
    send(16'hE000, 1'b0, 0, 16'h0, got);
    check("round_neg_half", 32'(got), 32'h0000);

    // Write/accept collision and out-of-range address
    send(16'h4000, 1'b1, 0, 16'h4000, got);
    check("collision", 32'(got), 32'h4000);
    write_coef(T, 16'h7FFF);
    send(16'h4000, 1'b0, 0, 16'h0, got);
    check("addr_oob", 32'(got), 32'h4000);

    // Randomized traffic with random backpressure
    for (int n = 0; n < 16; n++) begin
      int nw;
      bit we;
      nw = int'($urandom_range(0, 2));
      for (int j = 0; j < nw; j++)
        write_coef(int'($urandom_range(0, (1 << AW) - 1)), 16'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 3) == 0);
      send(16'($urandom), we, int'($urandom_range(0, (1 << AW) - 1)), 16'($urandom), got);
      if (!out_ready) hold_release(int'($urandom_range(1, 4)), 1'b0);
    end

    // Reset in the middle of MAC
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 16'h4000;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_coef_ready", 32'(coef_ready), 32'd1);
    model_clear();
    tick();
    rst_n = 1'b1;
    tick();
    for (int k = 0; k < T; k++) begin
      send((k == 0) ? 16'h4000 : 16'h0000, 1'b0, 0, 16'h0, got);
      check("post_reset_impulse", 32'(got), 32'h0000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
